// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, the instruction memory and decode.
// The master modport is the fetch unit's view; the slave modport is the
// environment (imem plus decode) that drives the redirect and handshakes.
interface fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               PCSrc_F;
  logic [ADDR_W-1:0]  PCBranch_F;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_addr_F;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid_D;
  logic               instr_ready_D;
  logic [INSTR_W-1:0] instr_D;
  logic [ADDR_W-1:0]  pc_D;
  logic [CNT_W-1:0]   queue_count;

  modport master (
    input  PCSrc_F, PCBranch_F, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           instr_ready_D,
    output imem_req_valid, imem_addr_F, instr_valid_D, instr_D, pc_D, queue_count
  );

  modport slave (
    output PCSrc_F, PCBranch_F, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           instr_ready_D,
    input  imem_req_valid, imem_addr_F, instr_valid_D, instr_D, pc_D, queue_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in
// flight, and buffers returned instructions with their PCs in a small FIFO
// toward decode. A redirect flushes the FIFO and turns any in-flight fetch
// into a dropped one so no wrong-path instruction ever reaches decode.
module fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4,
  parameter int                DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [ADDR_W-1:0]   r_req_pc;
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic [INSTR_W-1:0]  r_q_instr [DEPTH];
  logic [ADDR_W-1:0]   r_q_pc    [DEPTH];

  logic w_redir;
  logic w_full;
  logic w_empty;
  logic w_req_valid;
  logic w_req_fire;
  logic w_push;
  logic w_pop;

  // The redirect is ignored in IDLE; the issue rule keeps a FIFO slot free
  // for the single outstanding request, so a push never meets a full queue.
  assign w_redir     = bus.PCSrc_F && (r_state != S_IDLE);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_req_valid = (r_state == S_RUN) && !w_full && !bus.PCSrc_F;
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  assign w_push      = (r_state == S_WAIT) && bus.imem_rsp_valid && !w_redir;
  assign w_pop       = !w_empty && bus.instr_ready_D;

  // Next-state and next-PC selection; redirect wins over a sequential step.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_req_fire) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) w_state_nxt = S_RUN;
        else if (w_redir)       w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (bus.imem_rsp_valid) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_redir)         w_pc_nxt = bus.PCBranch_F;
    else if (w_req_fire) w_pc_nxt = r_pc + ADDR_W'(PC_STEP);
  end

  // FSM state, PC and the PC of the request currently in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_req_fire) r_req_pc <= r_pc;
    end
  end

  // FIFO pointers and occupancy; a flush overrides same-cycle push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_redir) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only observable through the occupancy gate.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wptr] <= bus.imem_rsp_data;
      r_q_pc[r_wptr]    <= r_req_pc;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr_F    = r_pc;
  assign bus.instr_valid_D  = !w_empty;
  assign bus.instr_D        = w_empty ? '0 : r_q_instr[r_rptr];
  assign bus.pc_D           = w_empty ? '0 : r_q_pc[r_rptr];
  assign bus.queue_count    = r_count;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage with a decoupled instruction-memory handshake and a small instruction queue toward decode. Holds the PC, issues one imem request at a time, and advances the PC by PC_STEP or redirects it to the branch target. Buffers returned instructions with their PCs. Flushes queued and in-flight fetches on redirect, so decode never sees wrong-path instructions.

Parameters:
ADDR_W, 64, PC / address width in bits
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value after reset (ADDR_W bits)
PC_STEP, 4, sequential PC increment
DEPTH, 4, instruction queue entries (power of two, >= 2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
PCSrc_F  in  1  redirect request this cycle
PCBranch_F  in  ADDR_W  redirect target PC
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_addr_F  out  ADDR_W  fetch address, equal to the current PC
imem_rsp_valid  in  1  response valid; arrives no earlier than 1 cycle after acceptance
imem_rsp_data  in  INSTR_W  fetched instruction
instr_valid_D  out  1  queue head valid
instr_ready_D  in  1  decode accepts head
instr_D  out  INSTR_W  head instruction
pc_D  out  ADDR_W  PC of head instruction
queue_count  out  $clog2(DEPTH)+1  occupied queue entries

Behaviour:
- Reset asserted (reset=0): pc=RESET_PC, state=IDLE, queue empty, in-flight PC register cleared.
- Output values during reset: imem_req_valid=0, imem_addr_F=RESET_PC, instr_valid_D=0, instr_D=0, pc_D=0, queue_count=0.
- Reset applies immediately. Any in-flight request is forgotten, and a late imem_rsp_valid in IDLE is ignored.
- States: IDLE, RUN, WAIT, DROP.
- IDLE -> RUN on the first clock edge after reset deasserts. No request is issued in IDLE.
- RUN:
  - imem_req_valid = (queue_count < DEPTH) && !PCSrc_F.
  - On handshake (valid && ready): latch req_pc=pc, set pc <= pc+PC_STEP (mod 2^ADDR_W, wraps silently), go to WAIT.
  - Without handshake: hold pc and imem_req_valid. The request must stay stable until it is accepted.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: push {imem_rsp_data, req_pc} into the queue, go to RUN.
  - Space for the push is guaranteed by the issue rule, since at most one request is outstanding.
- DROP:
  - imem_req_valid=0.
  - On imem_rsp_valid: discard the data, go to RUN.
- Redirect (PCSrc_F=1) takes priority in every state except IDLE:
  - pc <= PCBranch_F.
  - Queue flushed (count=0); the flush overrides any same-cycle pop or push.
  - No request is issued that cycle.
  - In WAIT with no response this cycle: go to DROP.
  - In WAIT with a response this cycle: discard the response, go to RUN.
  - In DROP: stay in DROP; a response this cycle is discarded and the state goes to RUN.
  - In RUN: stay in RUN.
  - In IDLE: redirect is ignored.
- Queue behaviour:
  - FIFO order.
  - Pop when instr_valid_D && instr_ready_D.
  - instr_valid_D = (count != 0); instr_D and pc_D show the head entry and are 0 when empty.
  - Simultaneous push and pop: count unchanged.
  - Full (count=DEPTH): no new issue; an already-issued response still pushes, because the issue rule reserved the slot.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Request issued -> instruction visible on instr_D the cycle after imem_rsp_valid (registered queue).
  - Peak throughput is one fetch per 2 cycles when the response returns 1 cycle after acceptance.

Test Plan:
- Reset release, RESET_PC=0x0, ready=1, response 1 cycle after each request -> addresses 0x0, 0x4, 0x8 issued; decode receives (pc 0x0, 0x4, 0x8) in order with the matching data.
- instr_ready_D=0 held, DEPTH=4 -> after 4 pushes queue_count=4 and imem_req_valid=0. Release ready for one cycle -> one pop, then exactly one new request at 0x10.
- imem_req_ready=0 for 3 cycles -> imem_req_valid=1 and imem_addr_F stable for all 3 cycles; pc advances only after acceptance.
- Redirect to 0x100 while in WAIT, response arrives 2 cycles later -> response discarded, queue empty; next request addr=0x100 and the first pc_D delivered is 0x100.
- Redirect to 0x200 in the same cycle as imem_rsp_valid with 2 entries queued and a pop -> queue_count=0, response discarded; next request addr=0x200.
- pc = 2^ADDR_W-4, step 4 -> next request addr=0x0 (wrap).
- Reset asserted mid-WAIT -> outputs return to reset values immediately; a later rsp_valid in IDLE has no effect; fetch restarts at RESET_PC.
